// File: rtl/image_stream_reader.sv
// Sequential frame reader: 2-cycle memory reads into a 2-entry pixel FIFO.
// Streams pixels with eol/last markers over a valid/ready interface.
module image_stream_reader #(
  parameter int ADDR_W   = 18,
  parameter int DATA_W   = 8,
  parameter int IMG_SIZE = 160000,
  parameter int IMG_W    = 400
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rd,
  output logic [DATA_W-1:0] px_data,
  output logic              px_valid,
  input  logic              px_ready,
  output logic              px_eol,
  output logic              px_last
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(IMG_SIZE - 1);
  localparam logic [CW-1:0]     LAST_C = CW'(IMG_W - 1);

  typedef enum logic [2:0] {
    IDLE, ISSUE, CAPTURE, WAIT, DRAIN
  } state_t;

  state_t state, state_nx;

  logic [ADDR_W-1:0] addr, addr_nx;
  logic [CW-1:0]     col, col_nx;
  logic [DATA_W+1:0] fifo [2];
  logic              wr_ptr, rd_ptr;
  logic [1:0]        count, cnt_pop;
  logic              push, pop;
  logic [DATA_W+1:0] head;

  assign px_valid = (count != 2'd0);
  assign pop      = px_valid & px_ready;
  assign cnt_pop  = count - {1'b0, pop};
  assign head     = fifo[rd_ptr];

  assign px_data = px_valid ? head[DATA_W+1:2] : '0;
  assign px_eol  = px_valid & head[1];
  assign px_last = px_valid & head[0];

  assign busy   = (state != IDLE);
  assign mem_we = 1'b0;
  assign mem_a  = (state == IDLE) ? '0 : addr;

  // Room is judged after this cycle's pop; CAPTURE also counts its own push.
  always_comb begin
    state_nx = state;
    addr_nx  = addr;
    col_nx   = col;
    push     = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nx = ISSUE;
          addr_nx  = '0;
          col_nx   = '0;
        end
      end
      ISSUE: state_nx = CAPTURE;
      CAPTURE: begin
        push = 1'b1;
        if (addr == LAST_A) begin
          state_nx = DRAIN;
        end else begin
          addr_nx  = addr + ADDR_W'(1);
          col_nx   = (col == LAST_C) ? '0 : col + CW'(1);
          state_nx = (cnt_pop == 2'd0) ? ISSUE : WAIT;
        end
      end
      WAIT: begin
        if (cnt_pop <= 2'd1) state_nx = ISSUE;
      end
      DRAIN: begin
        if (count == 2'd0) begin
          done     = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      addr  <= '0;
      col   <= '0;
    end else begin
      state <= state_nx;
      addr  <= addr_nx;
      col   <= col_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo[0] <= '0;
      fifo[1] <= '0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count   <= 2'd0;
    end else begin
      if (push) begin
        fifo[wr_ptr] <= {mem_rd, col == LAST_C, addr == LAST_A};
        wr_ptr       <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_image_stream_reader.sv
// Scoreboard bench for image_stream_reader with a synchronous-read memory
// model, randomized backpressure, restart, and mid-frame reset scenarios.
module tb_image_stream_reader;

  localparam int AW = 18;
  localparam int DW = 8;
  localparam int N  = 64;
  localparam int W  = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, mem_we;
  logic [AW-1:0] mem_a;
  logic [DW-1:0] mem_rd = '0;
  logic [DW-1:0] px_data;
  logic          px_valid, px_eol, px_last;
  logic          px_ready = 1'b0;

  image_stream_reader #(
    .ADDR_W(AW), .DATA_W(DW), .IMG_SIZE(N), .IMG_W(W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .busy(busy), .done(done),
    .mem_a(mem_a), .mem_we(mem_we), .mem_rd(mem_rd),
    .px_data(px_data), .px_valid(px_valid), .px_ready(px_ready),
    .px_eol(px_eol), .px_last(px_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       eol;
    logic       last;
  } px_t;

  px_t exp_q[$];
  int  tests = 0;
  int  fails = 0;
  int  dones = 0;
  int  busy_cyc = 0;
  int  seed_v = 0;
  int  ready_mode = 0;

  function automatic logic [7:0] pix(int i, int s);
    return 8'((i * 37) ^ s ^ (i >> 3));
  endfunction

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endtask

  // Memory answers one cycle after the address is presented.
  always @(posedge clk) mem_rd <= pix(int'(mem_a), seed_v);

  initial forever begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0: px_ready = 1'b1;
      1: px_ready = 1'($urandom_range(0, 1));
      default: px_ready = 1'b0;
    endcase
  end

  bit         stalled = 0;
  logic [9:0] held;

  always @(negedge clk) begin
    if (!rst_n) begin
      stalled = 0;
    end else begin
      if (stalled)
        chk("stall_hold", {px_valid, px_data, px_eol, px_last},
            {1'b1, held});
      if (px_valid && px_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_px", 1, 0);
        end else begin
          px_t e;
          e = exp_q.pop_front();
          chk("px_data", px_data, e.d);
          chk("px_eol", px_eol, e.eol);
          chk("px_last", px_last, e.last);
        end
      end
      stalled = px_valid && !px_ready;
      held = {px_data, px_eol, px_last};
      if (busy) busy_cyc++;
      if (done) begin
        dones++;
        chk("done_q_empty", exp_q.size(), 0);
      end
      if (int'(mem_a) >= N) chk("mem_a_range", mem_a, N - 1);
      if (dut.push && dut.count == 2'd2) chk("push_full", 1, 0);
    end
  end

  task automatic start_frame();
    seed_v = int'($urandom_range(0, 255));
    for (int i = 0; i < N; i++) begin
      px_t p;
      p.d = pix(i, seed_v);
      p.eol = ((i % W) == W - 1);
      p.last = (i == N - 1);
      exp_q.push_back(p);
    end
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done();
    int c;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!done && c < 3000);
    if (!done) chk("done_timeout", 0, 1);
  endtask

  task automatic chk_reset_outs(string n);
    chk({n, "_mem_a"}, mem_a, 0);
    chk({n, "_busy"}, busy, 0);
    chk({n, "_done"}, done, 0);
    chk({n, "_valid"}, px_valid, 0);
    chk({n, "_data"}, px_data, 0);
    chk({n, "_eol"}, px_eol, 0);
    chk({n, "_last"}, px_last, 0);
    chk({n, "_we"}, mem_we, 0);
  endtask

  task automatic end_frame(string n, int d0);
    repeat (4) @(negedge clk);
    chk({n, "_dones"}, dones, d0 + 1);
    chk({n, "_q"}, exp_q.size(), 0);
    chk({n, "_busy"}, busy, 0);
  endtask

  initial begin
    int d0;
    logic [AW-1:0] a0;
    repeat (3) @(posedge clk);
    #1 chk_reset_outs("reset");
    @(negedge clk) rst_n = 1'b1;

    // Full-rate frame: 2 clk per pixel plus issue and done cycles.
    ready_mode = 0;
    d0 = dones;
    busy_cyc = 0;
    start_frame();
    wait_done();
    end_frame("rate", d0);
    chk("busy_cycles", busy_cyc, 2 * N + 2);

    // Sustained stall fills the FIFO and freezes the read address.
    d0 = dones;
    start_frame();
    for (int c = 0; c < 100 && !px_valid; c++) @(negedge clk);
    ready_mode = 2;
    repeat (10) @(negedge clk);
    a0 = mem_a;
    repeat (10) @(negedge clk);
    chk("stall_mem_a", mem_a, a0);
    chk("stall_valid", px_valid, 1);
    chk("stall_busy", busy, 1);
    ready_mode = 0;
    wait_done();
    end_frame("stall", d0);

    // Random backpressure frames.
    for (int k = 0; k < 4; k++) begin
      ready_mode = 1;
      d0 = dones;
      start_frame();
      wait_done();
      end_frame("rand", d0);
    end

    // Start pulse mid-frame must not restart the frame.
    ready_mode = 1;
    d0 = dones;
    start_frame();
    repeat (10) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done();
    end_frame("restart", d0);

    // Start coinciding with done is ignored.
    ready_mode = 0;
    d0 = dones;
    start_frame();
    wait_done();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("start_at_done_busy", busy, 0);
    end_frame("start_at_done", d0);

    // Asynchronous reset in the middle of a frame.
    d0 = dones;
    start_frame();
    repeat (16) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset_outs("midrst");
    exp_q.delete();
    repeat (3) @(negedge clk);
    chk("midrst_no_done", dones, d0);
    rst_n = 1'b1;
    ready_mode = 1;
    start_frame();
    wait_done();
    end_frame("after_rst", d0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
